// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults for the FIFO control slice: pointer width, depth,
// watermark levels and the address width of the attached dual-port memory.
package fifo_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;
  localparam int DEF_AE_LEVEL   = 2;
  localparam int DEF_AF_LEVEL   = 6;
  localparam int MEM_ADDR_WIDTH = 4;

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// Wrap-bit pointer: low bits address the memory, MSB toggles on each pass
// through the array so that full and empty stay distinguishable.
module fifo_ptr #(
  parameter int W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [W:0] ptr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + (W + 1)'(1);
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control: push/pop acceptance, memory strobes and addresses, occupancy
// flags decoded from the registered pointers, and sticky error flags.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AE_LEVEL   = DEF_AE_LEVEL,
  parameter int AF_LEVEL   = DEF_AF_LEVEL
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  output logic                      write_enable,
  output logic                      read_enable,
  output logic [MEM_ADDR_WIDTH-1:0] write_addr,
  output logic [MEM_ADDR_WIDTH-1:0] read_addr,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ADDR_WIDTH:0]       count,
  output logic                      data_valid,
  output logic                      overflow,
  output logic                      underflow
);

  localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH + 1)'(AF_LEVEL);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;

  fifo_ptr #(.W(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (write_enable),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (read_enable),
    .ptr   (rd_ptr)
  );

  // Status depends only on the registered pointers, never on push/pop.
  assign count        = wr_ptr - rd_ptr;
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr == {~rd_ptr[ADDR_WIDTH], rd_ptr[ADDR_WIDTH-1:0]});
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // A pop frees the slot being written when full: the read sees old contents.
  assign write_enable = push & (~full | pop);
  assign read_enable  = pop & ~empty;

  assign write_addr = MEM_ADDR_WIDTH'(wr_ptr[ADDR_WIDTH-1:0]);
  assign read_addr  = MEM_ADDR_WIDTH'(rd_ptr[ADDR_WIDTH-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      data_valid <= read_enable;
      if (push & ~write_enable)
        overflow <= 1'b1;
      if (pop & ~read_enable)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a queue-based occupancy model is
// compared against every DUT output each cycle, plus directed literal checks.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic       pop;
  logic       write_enable;
  logic       read_enable;
  logic [3:0] write_addr;
  logic [3:0] read_addr;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       data_valid;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of accepted words plus running push/pop totals.
  int q[$];
  int m_wr;
  int m_rd;
  bit m_ovf;
  bit m_unf;
  bit m_dv;

  fifo_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .write_addr   (write_addr),
    .read_addr    (read_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .data_valid   (data_valid),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wr  = 0;
    m_rd  = 0;
    m_ovf = 0;
    m_unf = 0;
    m_dv  = 0;
  endtask

  task automatic model_step(input bit p, input bit r);
    bit we;
    bit re;
    int w;
    we = p && (q.size() < 8 || r);
    re = r && (q.size() > 0);
    if (p && !we) m_ovf = 1;
    if (r && !re) m_unf = 1;
    if (re) begin
      w = q.pop_front();
      m_rd++;
    end
    if (we) begin
      q.push_back(m_wr);
      m_wr++;
    end
    m_dv = re;
  endtask

  task automatic checkOutput();
    int n;
    n = q.size();
    chk("write_enable", int'(write_enable), int'(push && (n < 8 || pop)));
    chk("read_enable",  int'(read_enable),  int'(pop && n > 0));
    chk("write_addr",   int'(write_addr),   m_wr % 8);
    chk("read_addr",    int'(read_addr),    m_rd % 8);
    chk("count",        int'(count),        n);
    chk("full",         int'(full),         int'(n == 8));
    chk("empty",        int'(empty),        int'(n == 0));
    chk("almost_full",  int'(almost_full),  int'(n >= 6));
    chk("almost_empty", int'(almost_empty), int'(n <= 2));
    chk("data_valid",   int'(data_valid),   int'(m_dv));
    chk("overflow",     int'(overflow),     int'(m_ovf));
    chk("underflow",    int'(underflow),    int'(m_unf));
  endtask

  // Called at a negedge: drive inputs, compare, then advance through posedge.
  task automatic applyStimulus(input bit p, input bit r);
    push = p;
    pop  = r;
    #1;
    checkOutput();
    @(posedge clk);
    model_step(p, r);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    push  = 1'b0;
    pop   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_ae",    int'(almost_empty), 1);
    chk("rst_full",  int'(full), 0);
    checkOutput();
    reset = 1'b0;

    // Fill: addresses 0..7, almost_full after the 6th, full after the 8th.
    for (int i = 0; i < 8; i++) begin
      chk("fill_waddr", int'(write_addr), i);
      applyStimulus(1'b1, 1'b0);
      chk("fill_count", int'(count), i + 1);
      chk("fill_af", int'(almost_full), int'(i + 1 >= 6));
    end
    chk("fill_full", int'(full), 1);
    chk("fill_ovf", int'(overflow), 0);

    // Ninth push is rejected.
    push = 1'b1;
    #1;
    chk("ovf_we", int'(write_enable), 0);
    applyStimulus(1'b1, 1'b0);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_waddr", int'(write_addr), 0);
    chk("ovf_count", int'(count), 8);

    // Simultaneous push/pop while full keeps count at 8.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1);
      chk("pp_dv", int'(data_valid), 1);
    end
    chk("pp_count", int'(count), 8);
    chk("pp_raddr", int'(read_addr), 3);
    chk("pp_waddr", int'(write_addr), 3);

    // Drain completely, then pop-while-empty alongside a push.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1);
    chk("drain_empty", int'(empty), 1);
    push = 1'b1;
    pop  = 1'b1;
    #1;
    chk("unf_re", int'(read_enable), 0);
    applyStimulus(1'b1, 1'b1);
    chk("unf_flag", int'(underflow), 1);
    chk("unf_count", int'(count), 1);

    // Single word round trip: data_valid one cycle after the pop edge.
    applyStimulus(1'b0, 1'b1);
    chk("rt_dv", int'(data_valid), 1);
    applyStimulus(1'b0, 1'b0);
    chk("rt_dv_low", int'(data_valid), 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45));

    // Asynchronous reset mid-burst at count 5.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    chk("pre_rst_count", int'(count), 5);
    push = 1'b1;
    pop  = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    push = 1'b0;
    pop  = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_dv",    int'(data_valid), 0);
    chk("arst_ovf",   int'(overflow), 0);
    chk("arst_unf",   int'(underflow), 0);
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
